adaptive_binarizer: RTL and testbench
=====================================

Name: adaptive_binarizer

Overview:
- Parametrised successor to the fixed-threshold gray-to-binary stage. Sits between the grayscale converter and the frame buffer or display path in the capture pipeline.
- Converts a DW-bit gray pixel stream to full-scale black/white with 1-cycle latency.
- Threshold is either software-fixed or adaptive; the adaptive value is the mean gray level of the previous frame, computed by a sequential divider.
- Optional hysteresis band and output inversion.

Parameters:
- DW, 12, pixel data width.
- CNT_W, 22, pixel-count width per frame. Sum width SUM_W = DW+CNT_W.
- DEFAULT_THRESH, 1047, threshold after reset, used until the first valid mean exists.
- HYST, 32, half-width of the hysteresis band in gray levels.
- INVERT, 0, 1 swaps the black and white output codes.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous reset, active-high.
- iDATA  in  DW  gray pixel.
- iDVAL  in  1  pixel valid.
- iFVAL  in  1  frame valid; high for the whole frame.
- iMODE  in  2  0=fixed, 1=adaptive, 2=adaptive+hysteresis, 3=fixed+hysteresis.
- iTHRESH  in  DW  software threshold for fixed modes.
- oDATA  out  DW  binary pixel: all-ones or 0.
- oDVAL  out  1  oDATA valid.
- oTHRESH  out  DW  threshold currently applied.
- oBUSY  out  1  mean divider running.

Behaviour:
- Reset (iRST=1, asynchronous) clears state as follows:
  - oDATA=0, oDVAL=0, oBUSY=0.
  - oTHRESH=DEFAULT_THRESH; mean register=DEFAULT_THRESH; mean-valid flag=0.
  - sum=0, count=0, hysteresis state=0, divider state=IDLE.
- Reset mid-divide aborts the divide with no threshold update.
- Frame start is an iFVAL rising edge; frame end is an iFVAL falling edge. Both are detected with a registered copy of iFVAL.
- Threshold latch at frame start:
  - oTHRESH <= iTHRESH when iMODE[0]==iMODE[1] (modes 0 and 3).
  - Otherwise oTHRESH <= mean register.
  - Threshold and mode are frozen for the whole frame; iMODE or iTHRESH changes mid-frame take effect at the next frame start.
- Pixel path, 1-cycle latency:
  - oDVAL <= iDVAL every cycle.
  - oDATA is updated only when iDVAL=1; otherwise it holds.
  - Non-hysteresis modes: white when iDATA > oTHRESH (strict), else black.
  - Hysteresis modes:
    - hi = min(oTHRESH+HYST, 2^DW-1); lo = max(oTHRESH-HYST, 0), saturating, no wrap.
    - iDATA > hi -> white. iDATA < lo -> black. Otherwise repeat the previous decision.
    - The previous decision is cleared to black at frame start.
  - White = all-ones and black = 0 when INVERT=0; swapped when INVERT=1.
- Accumulation:
  - At frame start, sum and count clear; the first pixel of the frame is accumulated in that same cycle if iDVAL=1.
  - Accumulate while iFVAL&iDVAL: sum += iDATA, count += 1.
  - When count reaches 2^CNT_W-1, accumulation stops for both sum and count for the rest of the frame (no wrap).
- Divider FSM, states IDLE -> DIV -> UPDATE -> IDLE:
  - At frame end with count!=0: snapshot sum and count, go to DIV, assert oBUSY.
  - At frame end with count==0: no action; the mean is unchanged.
  - DIV: restoring division, one quotient bit per cycle, SUM_W cycles.
  - UPDATE: 1 cycle. mean <= min(quotient, 2^DW-1), floor division. Set mean-valid. Deassert oBUSY on the cycle after UPDATE.
  - A frame end arriving while the FSM is not IDLE is ignored for that frame; the mean is not updated.
  - A frame start during DIV latches the old mean. The new mean applies from the following frame. Accumulation of the new frame proceeds in parallel, independent of the snapshot.
- oDATA depends only on registered state, so there are no combinational paths from inputs to outputs.

Test Plan:
- Fixed mode, iTHRESH=1047, 12-bit:
  - iDATA=1047 then 1048 with iDVAL=1 -> oDATA=0 then 4095, each 1 cycle later; oDVAL tracks iDVAL delayed by 1.
- Adaptive mode:
  - Frame of pixels 100, 200, 300, 401 -> oBUSY high for 35 cycles after frame end; the following frame start sets oTHRESH=250.
  - Pixel 251 in that frame -> 4095; pixel 250 -> 0.
- Empty frame (iFVAL pulse, no iDVAL) -> oBUSY stays 0; oTHRESH unchanged at the next frame start.
- Hysteresis, mode 3, iTHRESH=1000, HYST=32:
  - Pixels 1040, 1010, 960, 1010 -> 4095, 4095, 0, 0.
  - iTHRESH=10 -> lo clamps to 0, so pixel 0 -> hold rather than black.
  - iTHRESH=4090 -> hi clamps to 4095, so no pixel can turn white.
- Timing of changes:
  - Change iMODE from 0 to 1 mid-frame -> oTHRESH and decisions unchanged until the next frame start.
  - Second frame starting 5 cycles after frame end -> that frame uses the old mean; the frame after uses the new mean.
- Reset:
  - Assert iRST during DIV -> all outputs reset immediately (asynchronous); oTHRESH=1047; no mean update after release.
  - INVERT=1 build -> the fixed-mode case yields 4095 then 0.

Source files
------------

// File: rtl/adaptive_binarizer.sv
`default_nettype none
// ============================================================================
// Module  : adaptive_binarizer
// Brief   : Gray to black/white pixel stage, threshold fixed or previous-frame mean.
// Revision: 1.0
// ============================================================================
module adaptive_binarizer #(
    parameter int DW             = 12,
    parameter int CNT_W          = 22,
    parameter int DEFAULT_THRESH = 1047,
    parameter int HYST           = 32,
    parameter bit INVERT         = 1'b0
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [DW-1:0] iDATA,
    input  logic          iDVAL,
    input  logic          iFVAL,
    input  logic [1:0]    iMODE,
    input  logic [DW-1:0] iTHRESH,
    output logic [DW-1:0] oDATA,
    output logic          oDVAL,
    output logic [DW-1:0] oTHRESH,
    output logic          oBUSY
);
    localparam int SUM_W = DW + CNT_W;
    localparam int BIT_W = $clog2(SUM_W);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIV    = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    localparam logic [DW-1:0]    c_DEFAULT = DW'(DEFAULT_THRESH);
    localparam logic [DW:0]      c_HYST    = (DW+1)'(HYST);
    localparam logic [DW-1:0]    c_MAX_PIX = '1;
    localparam logic [CNT_W-1:0] c_MAX_CNT = '1;

    logic             r_fval_d;
    logic [1:0]       r_mode;
    logic             r_hyst;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_state;
    logic [BIT_W-1:0] r_bit;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_div;
    logic [SUM_W-1:0] r_quot;
    logic [DW-1:0]    r_mean;
    logic             r_mean_valid;

    logic             w_fstart;
    logic             w_fend;
    logic [DW-1:0]    w_new_thresh;
    logic [DW-1:0]    w_thresh;
    logic [1:0]       w_mode;
    logic             w_prev;
    logic [DW:0]      w_hi_sum;
    logic [DW-1:0]    w_hi;
    logic [DW-1:0]    w_lo;
    logic             w_white;
    logic [CNT_W:0]   w_trial;
    logic             w_ge;
    logic [CNT_W-1:0] w_diff;
    logic [DW-1:0]    w_quot_sat;

    assign w_fstart     = iFVAL & ~r_fval_d;
    assign w_fend       = ~iFVAL & r_fval_d;
    assign w_new_thresh = (iMODE[0] == iMODE[1]) ? iTHRESH
                        : (r_mean_valid ? r_mean : c_DEFAULT);

    // The frame-start cycle already decides with the threshold and mode being latched.
    assign w_thresh = w_fstart ? w_new_thresh : oTHRESH;
    assign w_mode   = w_fstart ? iMODE : r_mode;
    assign w_prev   = w_fstart ? 1'b0 : r_hyst;

    assign w_hi_sum = {1'b0, w_thresh} + c_HYST;
    assign w_hi     = w_hi_sum[DW] ? c_MAX_PIX : w_hi_sum[DW-1:0];
    assign w_lo     = ({1'b0, w_thresh} < c_HYST) ? '0 : (w_thresh - c_HYST[DW-1:0]);

    always_comb begin
        w_white = (iDATA > w_thresh);
        if (w_mode[1]) begin
            if (iDATA > w_hi)
                w_white = 1'b1;
            else if (iDATA < w_lo)
                w_white = 1'b0;
            else
                w_white = w_prev;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_fval_d <= 1'b0;
            r_mode   <= 2'd0;
            r_hyst   <= 1'b0;
            oTHRESH  <= c_DEFAULT;
            oDATA    <= '0;
            oDVAL    <= 1'b0;
        end else begin
            r_fval_d <= iFVAL;
            oDVAL    <= iDVAL;
            if (w_fstart) begin
                oTHRESH <= w_new_thresh;
                r_mode  <= iMODE;
            end
            if (iDVAL) begin
                oDATA  <= {DW{w_white ^ INVERT}};
                r_hyst <= w_white;
            end else if (w_fstart) begin
                r_hyst <= 1'b0;
            end
        end
    end

    // Saturating per-frame accumulation; counting stops at the all-ones count.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (w_fstart) begin
            r_sum <= iDVAL ? SUM_W'(iDATA) : '0;
            r_cnt <= CNT_W'(iDVAL);
        end else if (iFVAL && iDVAL && (r_cnt != c_MAX_CNT)) begin
            r_sum <= r_sum + SUM_W'(iDATA);
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_trial    = {r_rem, r_quot[SUM_W-1]};
    assign w_ge       = (w_trial >= {1'b0, r_div});
    assign w_diff     = w_trial[CNT_W-1:0] - r_div;
    assign w_quot_sat = (|r_quot[SUM_W-1:DW]) ? c_MAX_PIX : r_quot[DW-1:0];

    // Restoring divider: dividend shifts out of r_quot while quotient bits shift in.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state      <= S_IDLE;
            r_bit        <= '0;
            r_rem        <= '0;
            r_div        <= '0;
            r_quot       <= '0;
            r_mean       <= c_DEFAULT;
            r_mean_valid <= 1'b0;
            oBUSY        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fend && (r_cnt != '0)) begin
                        r_quot  <= r_sum;
                        r_div   <= r_cnt;
                        r_rem   <= '0;
                        r_bit   <= BIT_W'(SUM_W - 1);
                        r_state <= S_DIV;
                        oBUSY   <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_quot <= {r_quot[SUM_W-2:0], w_ge};
                    r_rem  <= w_ge ? w_diff : w_trial[CNT_W-1:0];
                    if (r_bit == '0)
                        r_state <= S_UPDATE;
                    else
                        r_bit <= r_bit - 1'b1;
                end
                S_UPDATE: begin
                    r_mean       <= w_quot_sat;
                    r_mean_valid <= 1'b1;
                    r_state      <= S_IDLE;
                    oBUSY        <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    oBUSY   <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_adaptive_binarizer.sv
`default_nettype none
// ============================================================================
// Module  : tb_adaptive_binarizer
// Brief   : Scoreboard bench for adaptive_binarizer (normal and inverted builds).
// Revision: 1.0
// ============================================================================
module tb_adaptive_binarizer;
    logic        clk;
    logic        rst;
    logic [11:0] data;
    logic        dval;
    logic        fval;
    logic [1:0]  mode;
    logic [11:0] thresh;
    logic [11:0] o_data, i_data_inv, o_thresh, inv_thresh;
    logic        o_dval, o_busy, inv_dval, inv_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [11:0] got_inv_q[$];

    adaptive_binarizer #(.DW(12), .CNT_W(22), .DEFAULT_THRESH(1047), .HYST(32), .INVERT(1'b0)) dut (
        .iCLK(clk), .iRST(rst), .iDATA(data), .iDVAL(dval), .iFVAL(fval), .iMODE(mode),
        .iTHRESH(thresh), .oDATA(o_data), .oDVAL(o_dval), .oTHRESH(o_thresh), .oBUSY(o_busy)
    );

    adaptive_binarizer #(.DW(12), .CNT_W(22), .DEFAULT_THRESH(1047), .HYST(32), .INVERT(1'b1)) dut_inv (
        .iCLK(clk), .iRST(rst), .iDATA(data), .iDVAL(dval), .iFVAL(fval), .iMODE(mode),
        .iTHRESH(thresh), .oDATA(i_data_inv), .oDVAL(inv_dval), .oTHRESH(inv_thresh), .oBUSY(inv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (o_dval === 1'b1) got_q.push_back(o_data);
        if (inv_dval === 1'b1) got_inv_q.push_back(i_data_inv);
    end

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_inv_q.delete();
    endtask

    task automatic pix(input logic [11:0] d, input logic [11:0] e);
        @(negedge clk);
        data = d;
        dval = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dval = 1'b0;
        end
    endtask

    task automatic frame_start(input logic [1:0] m, input logic [11:0] t);
        @(negedge clk);
        mode   = m;
        thresh = t;
        fval   = 1'b1;
        dval   = 1'b0;
    endtask

    task automatic frame_end();
        @(negedge clk);
        fval = 1'b0;
        dval = 1'b0;
    endtask

    task automatic test_reset();
        n_checks += 4;
        if (o_data !== 12'd0)    begin n_fail++; $display("FAIL reset_data got %0d required 0", o_data); end
        if (o_dval !== 1'b0)     begin n_fail++; $display("FAIL reset_dval got %0b required 0", o_dval); end
        if (o_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %0b required 0", o_busy); end
        if (o_thresh !== 12'd1047) begin n_fail++; $display("FAIL reset_thresh got %0d required 1047", o_thresh); end
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        n_checks++;
        if (o_thresh !== 12'd1047) begin n_fail++; $display("FAIL post_reset_thresh got %0d required 1047", o_thresh); end
    endtask

    task automatic test_fixed();
        logic [11:0] e, g;
        clear_sb();
        frame_start(2'd0, 12'd1047);
        pix(12'd1047, 12'd0);
        @(posedge clk); #1;
        n_checks++;
        if (o_dval !== 1'b1) begin n_fail++; $display("FAIL fixed_dval_hi got %0b required 1", o_dval); end
        pix(12'd1048, 12'd4095);
        pix(12'd0, 12'd0);
        pix(12'd4095, 12'd4095);
        idle(1);
        @(posedge clk); #1;
        n_checks += 2;
        if (o_dval !== 1'b0) begin n_fail++; $display("FAIL fixed_dval_lo got %0b required 0", o_dval); end
        if (o_thresh !== 12'd1047) begin n_fail++; $display("FAIL fixed_thresh got %0d required 1047", o_thresh); end
        frame_end();
        idle(40);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL fixed_pix missing output, required %0d", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL fixed_pix got %0d required %0d", g, e); end
            end
        end
    endtask

    task automatic test_invert();
        logic [11:0] e, g;
        clear_sb();
        frame_start(2'd0, 12'd1047);
        pix(12'd1047, 12'd0);
        pix(12'd1048, 12'd4095);
        frame_end();
        idle(40);
        while (exp_q.size() != 0) begin
            e = ~exp_q.pop_front();
            n_checks++;
            if (got_inv_q.size() == 0) begin n_fail++; $display("FAIL invert_pix missing output, required %0d", e); end
            else begin
                g = got_inv_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL invert_pix got %0d required %0d", g, e); end
            end
        end
    endtask

    task automatic test_mode_change();
        logic [11:0] e, g;
        clear_sb();
        frame_start(2'd0, 12'd2000);
        pix(12'd1500, 12'd0);
        mode   = 2'd1;
        thresh = 12'd100;
        pix(12'd1500, 12'd0);
        @(posedge clk); #1;
        n_checks++;
        if (o_thresh !== 12'd2000) begin n_fail++; $display("FAIL midframe_thresh got %0d required 2000", o_thresh); end
        frame_end();
        idle(40);
        frame_start(2'd1, 12'd100);
        @(posedge clk); #1;
        n_checks++;
        if (o_thresh !== 12'd1500) begin n_fail++; $display("FAIL next_frame_thresh got %0d required 1500", o_thresh); end
        pix(12'd1501, 12'd4095);
        frame_end();
        idle(40);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL mode_pix missing output, required %0d", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL mode_pix got %0d required %0d", g, e); end
            end
        end
    endtask

    task automatic test_adaptive();
        logic [11:0] e, g;
        int busy_cnt;
        clear_sb();
        frame_start(2'd1, 12'd0);
        @(posedge clk); #1;
        n_checks++;
        if (o_thresh !== 12'd1501) begin n_fail++; $display("FAIL adapt_thresh1 got %0d required 1501", o_thresh); end
        pix(12'd100, 12'd0);
        pix(12'd200, 12'd0);
        pix(12'd300, 12'd0);
        pix(12'd401, 12'd0);
        frame_end();
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            dval = 1'b0;
            if (o_busy === 1'b1) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        n_checks++;
        if (busy_cnt != 35) begin n_fail++; $display("FAIL busy_cycles got %0d required 35", busy_cnt); end
        frame_start(2'd1, 12'd0);
        @(posedge clk); #1;
        n_checks++;
        if (o_thresh !== 12'd250) begin n_fail++; $display("FAIL adapt_mean got %0d required 250", o_thresh); end
        pix(12'd251, 12'd4095);
        pix(12'd250, 12'd0);
        frame_end();
        idle(40);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL adapt_pix missing output, required %0d", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL adapt_pix got %0d required %0d", g, e); end
            end
        end
    endtask

    task automatic test_empty();
        int busy_cnt;
        frame_start(2'd1, 12'd0);
        idle(3);
        frame_end();
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_busy !== 1'b0) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 0) begin n_fail++; $display("FAIL empty_busy got %0d busy cycles required 0", busy_cnt); end
        frame_start(2'd1, 12'd0);
        @(posedge clk); #1;
        n_checks++;
        if (o_thresh !== 12'd250) begin n_fail++; $display("FAIL empty_thresh got %0d required 250", o_thresh); end
        frame_end();
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [11:0] e, g;
        clear_sb();
        frame_start(2'd1, 12'd0);
        for (int i = 0; i < 4; i++) pix(12'd1000, 12'd4095);
        frame_end();
        idle(4);
        frame_start(2'd1, 12'd0);
        @(posedge clk); #1;
        n_checks++;
        if (o_thresh !== 12'd250) begin n_fail++; $display("FAIL b2b_old_mean got %0d required 250", o_thresh); end
        pix(12'd500, 12'd4095);
        pix(12'd600, 12'd4095);
        frame_end();
        idle(40);
        frame_start(2'd1, 12'd0);
        @(posedge clk); #1;
        n_checks++;
        if (o_thresh !== 12'd1000) begin n_fail++; $display("FAIL b2b_new_mean got %0d required 1000", o_thresh); end
        pix(12'd999, 12'd0);
        pix(12'd1001, 12'd4095);
        frame_end();
        idle(40);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL b2b_pix missing output, required %0d", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL b2b_pix got %0d required %0d", g, e); end
            end
        end
    endtask

    task automatic test_hyst();
        logic [11:0] e, g;
        clear_sb();
        frame_start(2'd3, 12'd1000);
        pix(12'd1040, 12'd4095);
        pix(12'd1010, 12'd4095);
        pix(12'd960,  12'd0);
        pix(12'd1010, 12'd0);
        frame_end();
        idle(40);
        frame_start(2'd3, 12'd10);
        pix(12'd50, 12'd4095);
        pix(12'd0,  12'd4095);
        pix(12'd30, 12'd4095);
        frame_end();
        idle(40);
        frame_start(2'd3, 12'd4090);
        pix(12'd4095, 12'd0);
        pix(12'd4000, 12'd0);
        frame_end();
        idle(40);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL hyst_pix missing output, required %0d", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL hyst_pix got %0d required %0d", g, e); end
            end
        end
    endtask

    task automatic test_reset_during_div();
        int busy_cnt;
        clear_sb();
        frame_start(2'd0, 12'd100);
        pix(12'd3000, 12'd4095);
        pix(12'd3000, 12'd4095);
        frame_end();
        idle(5);
        n_checks += 2;
        if (o_busy !== 1'b1) begin n_fail++; $display("FAIL div_running got %0b required 1", o_busy); end
        if (o_data !== 12'd4095) begin n_fail++; $display("FAIL pre_reset_data got %0d required 4095", o_data); end
        #2;
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (o_busy !== 1'b0)       begin n_fail++; $display("FAIL async_busy got %0b required 0", o_busy); end
        if (o_data !== 12'd0)      begin n_fail++; $display("FAIL async_data got %0d required 0", o_data); end
        if (o_dval !== 1'b0)       begin n_fail++; $display("FAIL async_dval got %0b required 0", o_dval); end
        if (o_thresh !== 12'd1047) begin n_fail++; $display("FAIL async_thresh got %0d required 1047", o_thresh); end
        @(negedge clk);
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_busy !== 1'b0) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 0) begin n_fail++; $display("FAIL post_reset_busy got %0d busy cycles required 0", busy_cnt); end
        frame_start(2'd1, 12'd0);
        @(posedge clk); #1;
        n_checks++;
        if (o_thresh !== 12'd1047) begin n_fail++; $display("FAIL post_reset_mean got %0d required 1047", o_thresh); end
        frame_end();
        idle(2);
    endtask

    initial begin
        rst    = 1'b1;
        fval   = 1'b0;
        dval   = 1'b0;
        data   = 12'd0;
        mode   = 2'd0;
        thresh = 12'd1047;
        repeat (3) @(negedge clk);
        test_reset();
        test_fixed();
        test_invert();
        test_mode_change();
        test_adaptive();
        test_empty();
        test_back_to_back();
        test_hyst();
        test_reset_during_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete, required finish before 500000");
        $fatal(1);
    end
endmodule
`default_nettype wire
